ft_tx_packetizer: RTL and testbench
===================================

FT_TX_PACKETIZER -- requirements
Module: ft_tx_packetizer

Interface
REQ-001 SHALL have parameter PKT_SAMPLES, default 16, range 1..255: 16-bit samples per packet.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5: packet sync byte.
REQ-003 SHALL have port FT_CLK  input  1  sole clock (FT245 synchronous-FIFO clock, 60 MHz).
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  permits starting new packets (from enable_sw, already synchronised).
REQ-006 SHALL have port s_data  input  16  sample from the upstream FFT/ADC FIFO.
REQ-007 SHALL have port s_valid  input  1  s_data valid.
REQ-008 SHALL have port s_ready  output  1  sample consumed on the edge where s_valid&&s_ready.
REQ-009 SHALL have port FT_TXE_N  input  1  FTDI transmit FIFO has space when low.
REQ-010 SHALL have port FT_DATA_OUT  output  8  byte to the FT_DATA tristate in System_Top.
REQ-011 SHALL have port FT_WR_N  output  1  write strobe, active-low, registered.
REQ-012 SHALL have port busy  output  1  high from packet start until its checksum byte is accepted.
REQ-013 SHALL have port pkt_seq  output  8  sequence number of the next packet.

Function
REQ-014 SHALL send each packet as HDR_BYTE, pkt_seq, PKT_SAMPLES, then each sample MSB then LSB, then a checksum equal to the XOR of all preceding bytes of the packet.
REQ-015 SHALL accept a byte only on a rising FT_CLK edge where FT_WR_N==0 and FT_TXE_N==0; FT_DATA_OUT SHALL hold stable until then.
REQ-016 SHALL register FT_WR_N low while a byte is pending and FT_TXE_N was low at that edge; FT_TXE_N going high SHALL cause no lost or duplicated byte.
REQ-017 SHALL implement states IDLE, HDR, SEQ, LEN, DATA_HI, DATA_LO, CSUM; each transmit state SHALL advance only on byte acceptance.
REQ-018 SHALL go IDLE->HDR on the edge where enable&&s_valid; with FT_TXE_N low, FT_WR_N SHALL fall on that same edge with FT_DATA_OUT=HDR_BYTE.
REQ-019 SHALL make LEN->DATA_HI capture the sample (s_ready high for exactly one cycle with s_valid); DATA_HI with s_valid low SHALL stall with FT_WR_N high.
REQ-020 SHALL take DATA_LO->DATA_HI while samples remain, and DATA_LO->CSUM after sample PKT_SAMPLES.
REQ-021 SHALL, on CSUM acceptance, increment pkt_seq modulo 256 (255->0) and return to IDLE; the next packet SHALL start no earlier than the following edge.
REQ-022 SHALL complete an in-progress packet when enable is deasserted; new packets SHALL not start.
REQ-023 SHALL keep s_ready low in all states except the sample-capture cycle, and SHALL never consume a sample in IDLE.
REQ-024 SHALL use an 8-bit running XOR, cleared in IDLE.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-packet, immediately force state IDLE, FT_WR_N=1, FT_DATA_OUT=0, s_ready=0, busy=0, pkt_seq=0, checksum=0, sample counter=0; any partial packet SHALL be discarded.
REQ-026 SHALL not start a packet before the first edge after rst_n deasserts.

Structure
REQ-027 SHALL take the state encoding, HDR_BYTE default and packet byte-offset constants from shared package ft_pkg, also used by the host-side decoder model.
REQ-028 SHALL be a single module; the FT_DATA tristate and FT_OE_N/FT_RD_N tie-offs SHALL remain in System_Top.

Verification
REQ-029 SHALL be checked with PKT_SAMPLES=2, TXE_N low, samples 0x1234 and 0xABCD: bytes A5 00 02 12 34 AB CD E7 on 8 consecutive accepting edges, then pkt_seq=1.
REQ-030 SHALL be checked with TXE_N pulsed high for 3 cycles during byte 0x34: the byte stream is unchanged and FT_WR_N is low only on accepting or pending cycles.
REQ-031 SHALL be checked with s_valid low for 5 cycles before the second sample: FT_WR_N stays high in DATA_HI and the stream is identical to REQ-029.
REQ-032 SHALL be checked with 257 packets sent: the seq byte reads FF on packet 256 and 00 on packet 257.
REQ-033 SHALL be checked with rst_n asserted at byte 4: outputs reach reset values immediately, and after release a fresh packet starts with seq 00.
REQ-034 SHALL be checked with enable dropped after the HDR byte: the packet completes with a correct checksum and no further packet starts while s_valid stays high.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared FT245 packet definitions: transmit FSM encoding, sync byte and byte
// offsets within a packet, used by the transmitter and the host-side decoder model.
package ft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_SEQ     = 3'd2,
        ST_LEN     = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_DATA_LO = 3'd5,
        ST_CSUM    = 3'd6
    } ft_state_t;

    localparam logic [7:0] FT_HDR_BYTE = 8'hA5;

    localparam int OFF_HDR  = 0;
    localparam int OFF_SEQ  = 1;
    localparam int OFF_LEN  = 2;
    localparam int OFF_DATA = 3;

    // Checksum sits right after the last sample byte.
    function automatic int csum_offset(input int samples);
        return OFF_DATA + 2 * samples;
    endfunction

    function automatic int pkt_bytes(input int samples);
        return csum_offset(samples) + 1;
    endfunction

endpackage

// File: rtl/ft_tx_packetizer.sv
// Frames 16-bit samples into sync/seq/len/data/checksum packets and writes them
// byte by byte into an FT245 synchronous FIFO with a registered write strobe.
module ft_tx_packetizer
    import ft_pkg::*;
#(
    parameter int         PKT_SAMPLES = 16,
    parameter logic [7:0] HDR_BYTE    = FT_HDR_BYTE
) (
    input  logic        FT_CLK,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        FT_TXE_N,
    output logic [7:0]  FT_DATA_OUT,
    output logic        FT_WR_N,
    output logic        busy,
    output logic [7:0]  pkt_seq
);

    localparam logic [7:0] LEN_BYTE = 8'(PKT_SAMPLES);
    localparam logic [7:0] LAST_IDX = 8'(PKT_SAMPLES - 1);

    ft_state_t  state_reg, state_next;
    logic       wr_n_reg,  wr_n_next;
    logic       pend_reg,  pend_next;
    logic [7:0] data_reg,  data_next;
    logic [7:0] csum_reg,  csum_next;
    logic [7:0] cnt_reg,   cnt_next;
    logic [7:0] lo_reg,    lo_next;
    logic [7:0] seq_reg,   seq_next;
    logic       busy_reg,  busy_next;
    logic       accept;
    logic       take_sample;

    // The FIFO takes the presented byte only when both strobe and space are low.
    assign accept = !wr_n_reg && !FT_TXE_N;

    always_ff @(posedge FT_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            wr_n_reg  <= 1'b1;
            pend_reg  <= 1'b0;
            data_reg  <= 8'h00;
            csum_reg  <= 8'h00;
            cnt_reg   <= 8'h00;
            lo_reg    <= 8'h00;
            seq_reg   <= 8'h00;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_n_reg  <= wr_n_next;
            pend_reg  <= pend_next;
            data_reg  <= data_next;
            csum_reg  <= csum_next;
            cnt_reg   <= cnt_next;
            lo_reg    <= lo_next;
            seq_reg   <= seq_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pend_next   = pend_reg;
        data_next   = data_reg;
        csum_next   = csum_reg;
        cnt_next    = cnt_reg;
        lo_next     = lo_reg;
        seq_next    = seq_reg;
        take_sample = 1'b0;

        if (accept) begin
            csum_next = csum_reg ^ data_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                csum_next = 8'h00;
                cnt_next  = 8'h00;
                pend_next = 1'b0;
                if (enable && s_valid) begin
                    state_next = ST_HDR;
                    data_next  = HDR_BYTE;
                    pend_next  = 1'b1;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    state_next = ST_SEQ;
                    data_next  = seq_reg;
                end
            end
            ST_SEQ: begin
                if (accept) begin
                    state_next = ST_LEN;
                    data_next  = LEN_BYTE;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    state_next  = ST_DATA_HI;
                    pend_next   = 1'b0;
                    take_sample = s_valid;
                end
            end
            ST_DATA_HI: begin
                // Without a byte loaded we are waiting on the upstream FIFO.
                if (!pend_reg) begin
                    take_sample = s_valid;
                end else if (accept) begin
                    state_next = ST_DATA_LO;
                    data_next  = lo_reg;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    cnt_next = cnt_reg + 8'd1;
                    if (cnt_reg == LAST_IDX) begin
                        state_next = ST_CSUM;
                        data_next  = csum_reg ^ data_reg;
                    end else begin
                        state_next  = ST_DATA_HI;
                        pend_next   = 1'b0;
                        take_sample = s_valid;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_next = ST_IDLE;
                    pend_next  = 1'b0;
                    seq_next   = seq_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pend_next  = 1'b0;
            end
        endcase

        // Capturing a sample loads its MSB immediately so the stream stays gapless.
        if (take_sample) begin
            data_next = s_data[15:8];
            lo_next   = s_data[7:0];
            pend_next = 1'b1;
        end

        wr_n_next = !(pend_next && !FT_TXE_N);
        busy_next = (state_next != ST_IDLE);
    end

    assign s_ready     = take_sample;
    assign FT_DATA_OUT = data_reg;
    assign FT_WR_N     = wr_n_reg;
    assign busy        = busy_reg;
    assign pkt_seq     = seq_reg;

endmodule

// File: tb/tb_ft_tx_packetizer.sv
// Self-checking bench for ft_tx_packetizer with two samples per packet: byte
// scoreboard, sample source with stalls, TXE_N throttling, reset and seq wrap.
module tb_ft_tx_packetizer;

    localparam int NS = 2;

    logic        FT_CLK   = 1'b0;
    logic        rst_n    = 1'b1;
    logic        enable   = 1'b0;
    logic [15:0] s_data   = 16'h0000;
    logic        s_valid  = 1'b0;
    logic        FT_TXE_N = 1'b0;
    logic        s_ready;
    logic [7:0]  FT_DATA_OUT;
    logic        FT_WR_N;
    logic        busy;
    logic [7:0]  pkt_seq;

    ft_tx_packetizer #(
        .PKT_SAMPLES(NS),
        .HDR_BYTE   (8'hA5)
    ) dut (
        .FT_CLK     (FT_CLK),
        .rst_n      (rst_n),
        .enable     (enable),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .FT_TXE_N   (FT_TXE_N),
        .FT_DATA_OUT(FT_DATA_OUT),
        .FT_WR_N    (FT_WR_N),
        .busy       (busy),
        .pkt_seq    (pkt_seq)
    );

    always #8 FT_CLK = ~FT_CLK;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] src_q[$];
    int          src_hold = 0;
    int          gap_after_fire = 0;
    int          txe_left = 0;
    int          txe_at = -1;
    bit          drop_at_hdr = 1'b0;
    bit          drop_now = 1'b0;
    int          pkt_acc, pkt_busy, pkt_wrlow, pkt_fire;
    logic [7:0]  obs[16];
    bit          last_busy = 1'b0;
    bit          prev_pend = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  seq_model = 8'h00;

    typedef struct {
        string       name;
        logic [15:0] s0;
        logic [15:0] s1;
        int          gap;
        int          txe_at;
        bit          drop;
        logic [7:0]  csum;
        int          exp_busy;
        int          exp_wrlow;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: observe at the falling edge, drive inputs just after the rising edge.
    task automatic tick();
        bit fire;
        @(negedge FT_CLK);
        fire = s_valid && s_ready;
        if (fire) pkt_fire++;
        if (prev_pend) chk("data_hold", 32'(FT_DATA_OUT), 32'(prev_data));
        prev_pend = !FT_WR_N && FT_TXE_N;
        prev_data = FT_DATA_OUT;
        if (!FT_WR_N) begin
            pkt_wrlow++;
            chk("busy_while_wr", 32'(busy), 32'd1);
        end
        if (busy) pkt_busy++;
        last_busy = busy;
        if (!FT_WR_N && !FT_TXE_N) begin
            if (pkt_acc < 16) obs[pkt_acc] = FT_DATA_OUT;
            pkt_acc++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_byte: got %02h expected none", FT_DATA_OUT);
            end else begin
                chk("byte", 32'(FT_DATA_OUT), 32'(exp_q.pop_front()));
            end
            if (pkt_acc == txe_at) txe_left = 3;
            if (pkt_acc == 1 && drop_at_hdr) drop_now = 1'b1;
        end
        @(posedge FT_CLK);
        #1;
        if (fire) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            if (gap_after_fire > 0) begin
                src_hold = gap_after_fire;
                gap_after_fire = 0;
            end
        end
        if (src_hold > 0) begin
            src_hold--;
            s_valid = 1'b0;
        end else begin
            s_valid = (src_q.size() > 0);
        end
        s_data = (src_q.size() > 0) ? src_q[0] : 16'h0000;
        if (txe_left > 0) begin
            FT_TXE_N = 1'b1;
            txe_left--;
        end else begin
            FT_TXE_N = 1'b0;
        end
        if (drop_now) begin
            enable = 1'b0;
            drop_now = 1'b0;
        end
    endtask

    task automatic start_packet(input logic [15:0] a, input logic [15:0] b, input logic [7:0] csum);
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq_model);
        exp_q.push_back(8'(NS));
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(b[15:8]);
        exp_q.push_back(b[7:0]);
        exp_q.push_back(csum);
        src_q.push_back(a);
        src_q.push_back(b);
        s_data    = src_q[0];
        s_valid   = 1'b1;
        enable    = 1'b1;
        pkt_acc   = 0;
        pkt_busy  = 0;
        pkt_wrlow = 0;
        pkt_fire  = 0;
    endtask

    task automatic run_packet(input string name, input int exp_busy, input int exp_wrlow);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (last_busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got busy=%0b expected packet end within 200 cycles", name, busy);
        end
        chk({name, "_busy_cycles"}, 32'(pkt_busy), 32'(exp_busy));
        chk({name, "_wr_low_cycles"}, 32'(pkt_wrlow), 32'(exp_wrlow));
        chk({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_samples_taken"}, 32'(pkt_fire), 32'(NS));
        seq_model = seq_model + 8'd1;
        chk({name, "_pkt_seq"}, 32'(pkt_seq), 32'(seq_model));
        $display("pkt %s seq=%02h csum=%02h busy=%0d wr_low=%0d", name, obs[1], obs[7], pkt_busy, pkt_wrlow);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_n", 32'(FT_WR_N), 32'd1);
        chk("rst_data", 32'(FT_DATA_OUT), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_seq", 32'(pkt_seq), 32'd0);
        repeat (3) @(posedge FT_CLK);
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("idle_wr_n", 32'(FT_WR_N), 32'd1);

        // name, s0, s1, gap, txe_at, drop, csum, busy cycles, wr_n-low cycles
        vecs[0] = '{"basic",  16'h1234, 16'hABCD, 0, -1, 1'b0, 8'hE7,  8, 8};
        vecs[1] = '{"txe",    16'h1234, 16'hABCD, 0,  4, 1'b0, 8'hE6, 12, 9};
        vecs[2] = '{"stall",  16'h1234, 16'hABCD, 5, -1, 1'b0, 8'hE5, 12, 8};
        vecs[3] = '{"endrop", 16'h1234, 16'hABCD, 0, -1, 1'b1, 8'hE4,  8, 8};
        vecs[4] = '{"ones",   16'h0000, 16'hFFFF, 0, -1, 1'b0, 8'hA3,  8, 8};
        vecs[5] = '{"split",  16'hFF00, 16'h00FF, 0, -1, 1'b0, 8'hA2,  8, 8};

        foreach (vecs[i]) begin
            gap_after_fire = vecs[i].gap;
            txe_at         = vecs[i].txe_at;
            drop_at_hdr    = vecs[i].drop;
            start_packet(vecs[i].s0, vecs[i].s1, vecs[i].csum);
            if (vecs[i].drop) src_q.push_back(16'h5555);
            run_packet(vecs[i].name, vecs[i].exp_busy, vecs[i].exp_wrlow);
            txe_at      = -1;
            drop_at_hdr = 1'b0;
            if (vecs[i].drop) begin
                pkt_busy = 0;
                repeat (10) tick();
                chk("endrop_no_restart", 32'(pkt_busy), 32'd0);
                chk("endrop_no_consume", 32'(src_q.size()), 32'd1);
                src_q.delete();
                s_valid = 1'b0;
                enable  = 1'b1;
            end
        end

        // Reset while byte 4 is on the bus: everything clears at once.
        start_packet(16'h1234, 16'hABCD, 8'h00);
        for (int c = 0; c < 50 && pkt_acc < 4; c++) tick();
        chk("rst_mid_reach", 32'(pkt_acc), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_n", 32'(FT_WR_N), 32'd1);
        chk("rst_mid_data", 32'(FT_DATA_OUT), 32'd0);
        chk("rst_mid_s_ready", 32'(s_ready), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_pkt_seq", 32'(pkt_seq), 32'd0);
        exp_q.delete();
        src_q.delete();
        s_valid   = 1'b0;
        enable    = 1'b0;
        prev_pend = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        seq_model = 8'h00;
        tick();

        // 257 packets from reset: seq byte must wrap FF -> 00.
        for (int k = 1; k <= 257; k++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic [7:0]  c;
            a = 16'($urandom);
            b = 16'($urandom);
            c = 8'hA5 ^ seq_model ^ 8'(NS) ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0];
            start_packet(a, b, c);
            run_packet("seq", 8, 8);
            if (k == 1)   chk("seq_byte_1", 32'(obs[1]), 32'h00);
            if (k == 256) chk("seq_byte_256", 32'(obs[1]), 32'hFF);
            if (k == 257) chk("seq_byte_257", 32'(obs[1]), 32'h00);
        end
        chk("final_pkt_seq", 32'(pkt_seq), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish expected finish before 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
